// File: rtl/filter_frame_sequencer.sv
// Frame sequencer for the 3x3 grayscale filter: walks a frame buffer in
// raster order and produces read, filter-timing and write-address strobes.
module filter_frame_sequencer #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int H_BLANK   = 4,
  parameter int VS_LEN    = 2,
  parameter int RD_LAT    = 1,
  parameter int DRAIN_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        filter_ready,
  output logic        rd_en,
  output logic [16:0] rd_addr,
  output logic        vsync,
  output logic        active_area,
  output logic        enable,
  output logic [16:0] pixel_addr,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE, VSYNC, LINE, HBLANK, DRAIN, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   rd_addr_q, rd_addr_d;
  logic [16:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          rd_en_q, rd_en_d;
  logic          vsync_q, vsync_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          en_pipe_q [RD_LAT];
  logic [16:0]   addr_pipe_q [RD_LAT];

  assign wr_en = filter_ready & busy_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q + 17'(wr_en);
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d   = VSYNC;
        x_d       = '0;
        y_d       = '0;
        cnt_d     = '0;
        rd_addr_d = '0;
        wr_addr_d = '0;
      end
      VSYNC: if (cnt_q == CW'(VS_LEN - 1)) begin
        state_d = LINE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      LINE: if (x_q == XW'(H_ACTIVE - 1)) begin
        state_d = HBLANK;
        cnt_d   = '0;
      end else begin
        x_d       = x_q + XW'(1);
        rd_addr_d = rd_addr_q + 17'(1);
      end
      HBLANK: if (cnt_q == CW'(H_BLANK - 1)) begin
        cnt_d = '0;
        // running address stays y*H_ACTIVE+x across the blank
        if (y_q < YW'(V_ACTIVE - 1)) begin
          state_d   = LINE;
          y_d       = y_q + YW'(1);
          x_d       = '0;
          rd_addr_d = rd_addr_q + 17'(1);
        end else begin
          state_d = DRAIN;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DRAIN: if (cnt_q == CW'(DRAIN_LEN - 1)) begin
        state_d     = DONE;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    vsync_d = (state_d == VSYNC);
    rd_en_d = (state_d == LINE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      frame_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      vsync_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        en_pipe_q[i]   <= 1'b0;
        addr_pipe_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
      frame_cnt_q    <= frame_cnt_d;
      rd_en_q        <= rd_en_d;
      vsync_q        <= vsync_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      en_pipe_q[0]   <= rd_en_q;
      addr_pipe_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe_q[i]   <= en_pipe_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign vsync       = vsync_q;
  assign active_area = en_pipe_q[RD_LAT-1];
  assign enable      = en_pipe_q[RD_LAT-1];
  assign pixel_addr  = addr_pipe_q[RD_LAT-1];
  assign wr_addr     = wr_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: doc/filter_frame_sequencer.md
# filter_frame_sequencer

Frame-level controller for the 8-bit grayscale 3x3 filter datapath. On a start request it walks a 320x240 frame buffer in raster order and issues read addresses. It generates the `vsync`, `active_area`, `enable` and `pixel_addr` strobes the filter expects, aligned to frame-buffer read latency. It counts filter results into a write address for the output buffer and reports busy/done to the capture/display control logic.

## Interface
- `H_ACTIVE`, 320: pixels per line.
- `V_ACTIVE`, 240: lines per frame.
- `H_BLANK`, 4: idle cycles between lines (≥1, so the filter sees an `active_area` rising edge per line).
- `VS_LEN`, 2: cycles `vsync` is held high at frame start (≥1).
- `RD_LAT`, 1: frame-buffer read latency in cycles (1..3).
- `DRAIN_LEN`, 4: cycles after the last line before `done` (covers filter pipeline).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `filter_ready` in 1: filter output valid.
- `rd_en` out 1: frame-buffer read strobe.
- `rd_addr` out 17: frame-buffer read address.
- `vsync` out 1: to filter.
- `active_area` out 1: to filter, delayed `RD_LAT`.
- `enable` out 1: to filter, equals `active_area`.
- `pixel_addr` out 17: `rd_addr` delayed `RD_LAT`.
- `wr_en` out 1: output-buffer write; equals `filter_ready` while busy.
- `wr_addr` out 17: output-buffer address.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `frame_cnt` out 8: completed frames, wraps 255→0.

## Operation
- States: IDLE, VSYNC, LINE, HBLANK, DRAIN, DONE.
- IDLE → VSYNC when `start`=1. On this transition, clear `x`, `y`, `rd_addr` and `wr_addr`.
- VSYNC: `vsync`=1 for `VS_LEN` cycles, then go to LINE.
- LINE: `rd_en`=1 every cycle. `rd_addr` increments by 1 per cycle. `x` counts 0..`H_ACTIVE`-1. At `x`=`H_ACTIVE`-1, go to HBLANK.
- HBLANK: `rd_en`=0 for `H_BLANK` cycles. Then:
  - if `y`<`V_ACTIVE`-1: `y`++, `x`=0, go to LINE;
  - otherwise go to DRAIN.
- `rd_addr` is a running counter, so it equals `y`*`H_ACTIVE`+`x` without a multiplier. The last read is at address 76799.
- DRAIN: `DRAIN_LEN` cycles, then go to DONE.
- DONE: `done`=1 for one cycle, `frame_cnt`++, go to IDLE.
- Delay pipe: a `RD_LAT`-deep shift register carries `rd_en` and `rd_addr`. Its outputs drive `active_area`/`enable` and `pixel_addr`, so the filter sees `active_area` aligned with the read data.
- `wr_addr` increments on every cycle with `wr_en`=1. It is not bounded by the sequencer; the filter determines the output count.
- `filter_ready` while IDLE is ignored: `wr_en`=0 and no increment.
- `start` while busy is ignored. `start` held high across DONE begins a new frame immediately from IDLE on the next cycle.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, including `rd_addr`, `pixel_addr`, `wr_addr` and `frame_cnt`; delay pipe cleared.
- Reset mid-frame aborts the frame immediately, with no `done` and no `frame_cnt` change.
- Cycle `T`: `start` sampled in IDLE. `busy`=1 and `vsync`=1 from `T`+1 through `T`+`VS_LEN`.
- First `rd_en` at `T`+`VS_LEN`+1. First `active_area` at `T`+`VS_LEN`+1+`RD_LAT`.
- Per-line period is `H_ACTIVE`+`H_BLANK` cycles. `rd_en` high for exactly `H_ACTIVE` consecutive cycles per line.
- Frame length from `T` to the `done` cycle: 1+`VS_LEN`+`V_ACTIVE`×(`H_ACTIVE`+`H_BLANK`)+`DRAIN_LEN`.
  - Defaults: 1+2+240×324+4 = 77767 cycles; `done` at `T`+77767.
- `busy` drops in the cycle after `done`.
- `active_area` is never high during VSYNC or more than `RD_LAT` cycles into HBLANK/DRAIN.
- `DRAIN_LEN` must be ≥ `RD_LAT`+2.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-LINE → all outputs 0 within the same cycle. Release with `start`=0 → stays IDLE, `busy`=0.
- Full frame, defaults: pulse `start` → 240 `active_area` rising edges, each followed by 320 high cycles. `pixel_addr` runs 0..76799 contiguously. `done` is a single pulse at `T`+77767. `frame_cnt`=1.
- Latency alignment, `RD_LAT`=1 and 3: `pixel_addr` equals `rd_addr` delayed exactly `RD_LAT` cycles. `active_area` rises `RD_LAT` cycles after `rd_en`.
- Write counting: drive `filter_ready` for 315 cycles per line → `wr_addr`=75600 at `done`. `filter_ready` pulsed in IDLE → `wr_en`=0, `wr_addr` unchanged.
- Start handling: `start` re-pulsed mid-frame → ignored, frame length unchanged. `start` held high → back-to-back frames, new `vsync` 2 cycles after `done`, `wr_addr` cleared.
- Wrap: run 256 frames (or use a reduced `H_ACTIVE`=4, `V_ACTIVE`=2 configuration) → `frame_cnt` goes 255→0.
